// File: rtl/shift_pair_pkg.sv
// Shared types for the shift_pair unit.
// Mode encoding and control FSM states.
package shift_pair_pkg;

  typedef enum logic [1:0] {
    MODE_LSR = 2'b00,
    MODE_ASR = 2'b01,
    MODE_ROR = 2'b10,
    MODE_LSL = 2'b11
  } mode_e;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_SHIFT = 2'b01,
    ST_DONE  = 2'b10
  } state_e;

endpackage

// File: rtl/shift_pair_ctrl.sv
// Sequencer for shift_pair_unit.
// Latches mode/count at start, paces shifts.
module shift_pair_ctrl
  import shift_pair_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int CNT_W = $clog2(2*WIDTH+1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start_i,
  input  logic [CNT_W-1:0] cnt_i,
  input  logic [1:0]       mode_i,
  output logic             shift_en,
  output logic             busy,
  output logic             done,
  output logic [1:0]       mode_o
);

  localparam int CW   = $clog2(2*WIDTH+1);
  localparam int MAXC = 2*WIDTH;

  state_e        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  mode_e         mode_q, mode_d;
  logic [CW-1:0] cnt_sat;

  // Requested count saturated to the chain length.
  always_comb begin
    cnt_sat = CW'(cnt_i);
    if (32'(cnt_i) > 32'(MAXC)) begin
      cnt_sat = CW'(MAXC);
    end
  end

  // Next state, counter and latched mode.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    mode_d  = mode_q;
    unique case (state_q)
      ST_IDLE: begin
        if (start_i) begin
          mode_d = mode_e'(mode_i);
          cnt_d  = cnt_sat;
          if (cnt_sat == '0) begin
            state_d = ST_DONE;
          end else begin
            state_d = ST_SHIFT;
          end
        end
      end
      ST_SHIFT: begin
        cnt_d = cnt_q - 1'b1;
        if (cnt_q == CW'(1)) begin
          state_d = ST_DONE;
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State register with asynchronous clear.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      mode_q  <= MODE_LSR;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      mode_q  <= mode_d;
    end
  end

  assign shift_en = (state_q == ST_SHIFT);
  assign busy     = (state_q == ST_SHIFT);
  assign done     = (state_q == ST_DONE);
  assign mode_o   = mode_q;

endmodule

// File: rtl/shift_pair_unit.sv
// Paired A/B shift register with loads,
// clear and a multi-cycle shift sequencer.
module shift_pair_unit
  import shift_pair_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int CNT_W = $clog2(2*WIDTH+1)
) (
  input  logic             Clk,
  input  logic             Reset,
  input  logic             Ld_A,
  input  logic             Ld_B,
  input  logic             Clr_A,
  input  logic [WIDTH-1:0] D,
  input  logic             Start,
  input  logic [CNT_W-1:0] Shift_Cnt,
  input  logic [1:0]       Mode,
  input  logic             Serial_In,
  output logic             Busy,
  output logic             Done,
  output logic [WIDTH-1:0] A,
  output logic [WIDTH-1:0] B,
  output logic             A_out,
  output logic             B_out
);

  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic             shift_en;
  logic             busy;
  logic             done;
  logic [1:0]       mode_q;
  logic             idle;
  logic             ld_any;
  logic             start_ok;

  assign idle     = !(busy || done);
  assign ld_any   = Ld_A || Ld_B || Clr_A;
  assign start_ok = Start && idle && !ld_any;

  shift_pair_ctrl #(
    .WIDTH (WIDTH),
    .CNT_W (CNT_W)
  ) u_ctrl (
    .clk      (Clk),
    .rst_n    (Reset),
    .start_i  (start_ok),
    .cnt_i    (Shift_Cnt),
    .mode_i   (Mode),
    .shift_en (shift_en),
    .busy     (busy),
    .done     (done),
    .mode_o   (mode_q)
  );

  // Loads in idle, one chain shift per enabled cycle.
  always_comb begin
    a_d = a_q;
    b_d = b_q;
    if (idle) begin
      if (Clr_A) begin
        a_d = '0;
      end else if (Ld_A) begin
        a_d = D;
      end
      if (Ld_B) begin
        b_d = D;
      end
    end else if (shift_en) begin
      unique case (mode_e'(mode_q))
        MODE_LSR:
          {a_d, b_d} = {Serial_In, a_q, b_q[WIDTH-1:1]};
        MODE_ASR:
          {a_d, b_d} = {a_q[WIDTH-1], a_q, b_q[WIDTH-1:1]};
        MODE_ROR:
          {a_d, b_d} = {b_q[0], a_q, b_q[WIDTH-1:1]};
        MODE_LSL:
          {a_d, b_d} = {a_q[WIDTH-2:0], b_q, Serial_In};
      endcase
    end
  end

  // Chain registers with asynchronous clear.
  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      a_q <= '0;
      b_q <= '0;
    end else begin
      a_q <= a_d;
      b_q <= b_d;
    end
  end

  assign A     = a_q;
  assign B     = b_q;
  assign A_out = a_q[0];
  assign B_out = b_q[0];
  assign Busy  = busy;
  assign Done  = done;

endmodule

// File: tb/tb_shift_pair_unit.sv
// Directed bench for shift_pair_unit.
// Vector table plus corner sequences.
module tb_shift_pair_unit;

  logic       Clk;
  logic       Reset;
  logic       Ld_A, Ld_B, Clr_A;
  logic [7:0] D;
  logic       Start;
  logic [4:0] Shift_Cnt;
  logic [1:0] Mode;
  logic       Serial_In;
  logic       Busy, Done;
  logic [7:0] A, B;
  logic       A_out, B_out;

  int total = 0;
  int bad   = 0;

  shift_pair_unit #(.WIDTH(8)) dut (
    .Clk       (Clk),
    .Reset     (Reset),
    .Ld_A      (Ld_A),
    .Ld_B      (Ld_B),
    .Clr_A     (Clr_A),
    .D         (D),
    .Start     (Start),
    .Shift_Cnt (Shift_Cnt),
    .Mode      (Mode),
    .Serial_In (Serial_In),
    .Busy      (Busy),
    .Done      (Done),
    .A         (A),
    .B         (B),
    .A_out     (A_out),
    .B_out     (B_out)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  typedef struct {
    logic [7:0] a0;
    logic [7:0] b0;
    logic [1:0] mode;
    logic [4:0] cnt;
    logic       sin;
    logic [7:0] ea;
    logic [7:0] eb;
    int         nb;
  } vec_t;

  vec_t v[9];

  task automatic chk(input string nm,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h",
               nm, act, exp);
    end
  endtask

  task automatic step();
    @(posedge Clk);
    #1;
  endtask

  task automatic load_ab(input logic [7:0] a,
                         input logic [7:0] b);
    Ld_A = 1'b1; D = a; step();
    Ld_A = 1'b0; Ld_B = 1'b1; D = b; step();
    Ld_B = 1'b0;
  endtask

  // Runs after the Start edge until Done.
  task automatic wait_done(output int nb,
                           output bit got);
    nb  = 0;
    got = 1'b0;
    for (int i = 0; i < 40; i++) begin
      if (Done) begin
        got = 1'b1;
        break;
      end
      if (Busy) nb++;
      step();
      Mode = ~Mode;
      Shift_Cnt = 5'd0;
    end
  endtask

  int nb;
  bit got;

  initial begin
    Reset = 1'b0; Ld_A = 0; Ld_B = 0; Clr_A = 0;
    D = 0; Start = 0; Shift_Cnt = 0;
    Mode = 0; Serial_In = 0;

    v[0] = '{8'h81, 8'h00, 2'b01, 5'd3,  1'b0,
             8'hF0, 8'h20, 3};
    v[1] = '{8'h12, 8'h34, 2'b10, 5'd16, 1'b0,
             8'h12, 8'h34, 16};
    v[2] = '{8'h00, 8'h01, 2'b11, 5'd20, 1'b0,
             8'h00, 8'h00, 16};
    v[3] = '{8'hAB, 8'hCD, 2'b00, 5'd0,  1'b1,
             8'hAB, 8'hCD, 0};
    v[4] = '{8'h00, 8'hFF, 2'b00, 5'd4,  1'b1,
             8'hF0, 8'h0F, 4};
    v[5] = '{8'h80, 8'h00, 2'b11, 5'd1,  1'b1,
             8'h00, 8'h01, 1};
    v[6] = '{8'h40, 8'h00, 2'b01, 5'd2,  1'b0,
             8'h10, 8'h00, 2};
    v[7] = '{8'h12, 8'h34, 2'b10, 5'd4,  1'b0,
             8'h41, 8'h23, 4};
    v[8] = '{8'hFF, 8'hFF, 2'b00, 5'd31, 1'b0,
             8'h00, 8'h00, 16};

    step(); step();
    chk("rst_A", 32'(A), 32'h0);
    chk("rst_B", 32'(B), 32'h0);
    chk("rst_busy", 32'(Busy), 32'h0);
    chk("rst_done", 32'(Done), 32'h0);
    Reset = 1'b1;
    step();

    for (int i = 0; i < 9; i++) begin
      load_ab(v[i].a0, v[i].b0);
      chk($sformatf("v%0d_ldA", i), 32'(A), 32'(v[i].a0));
      chk($sformatf("v%0d_ldB", i), 32'(B), 32'(v[i].b0));
      Start = 1'b1; Mode = v[i].mode;
      Shift_Cnt = v[i].cnt; Serial_In = v[i].sin;
      step();
      Start = 1'b0;
      wait_done(nb, got);
      chk($sformatf("v%0d_done", i), 32'(got), 32'h1);
      chk($sformatf("v%0d_busy", i), 32'(nb), 32'(v[i].nb));
      chk($sformatf("v%0d_A", i), 32'(A), 32'(v[i].ea));
      chk($sformatf("v%0d_B", i), 32'(B), 32'(v[i].eb));
      chk($sformatf("v%0d_Aout", i), 32'(A_out),
          32'(v[i].ea[0]));
      chk($sformatf("v%0d_Bout", i), 32'(B_out),
          32'(v[i].eb[0]));
      step();
      chk($sformatf("v%0d_pulse", i), 32'(Done), 32'h0);
      chk($sformatf("v%0d_idle", i), 32'(Busy), 32'h0);
    end

    // Loads, clear and Start blocked while busy.
    load_ab(8'h0F, 8'hF0);
    Start = 1'b1; Mode = 2'b00;
    Shift_Cnt = 5'd4; Serial_In = 1'b0;
    step();
    Start = 1'b0;
    step();
    Ld_A = 1; Ld_B = 1; Clr_A = 1;
    D = 8'h55; Start = 1'b1;
    step(); step();
    Ld_A = 0; Ld_B = 0; Clr_A = 0; Start = 1'b0;
    nb = 0; got = 0;
    for (int i = 0; i < 10; i++) begin
      if (Done) begin got = 1; break; end
      step();
    end
    chk("blk_done", 32'(got), 32'h1);
    chk("blk_A", 32'(A), 32'h00);
    chk("blk_B", 32'(B), 32'hFF);
    Start = 1'b1;
    step();
    Start = 1'b0;
    chk("dn_start_busy", 32'(Busy), 32'h0);
    step();
    chk("no_queue_busy", 32'(Busy), 32'h0);
    chk("no_queue_done", 32'(Done), 32'h0);

    // Start with clear: clear wins, no sequence.
    load_ab(8'h77, 8'h11);
    Start = 1'b1; Clr_A = 1'b1; Shift_Cnt = 5'd2;
    step();
    Start = 1'b0; Clr_A = 1'b0;
    chk("clr_A", 32'(A), 32'h00);
    chk("clr_B", 32'(B), 32'h11);
    chk("clr_busy", 32'(Busy), 32'h0);
    chk("clr_done", 32'(Done), 32'h0);
    step();
    chk("clr_busy2", 32'(Busy), 32'h0);

    // Reset mid-sequence, then restart at once.
    load_ab(8'hAA, 8'h55);
    Start = 1'b1; Mode = 2'b00; Shift_Cnt = 5'd5;
    step();
    Start = 1'b0;
    step(); step();
    chk("mid_busy_pre", 32'(Busy), 32'h1);
    #2;
    Reset = 1'b0;
    #1;
    chk("mr_A", 32'(A), 32'h0);
    chk("mr_B", 32'(B), 32'h0);
    chk("mr_busy", 32'(Busy), 32'h0);
    chk("mr_done", 32'(Done), 32'h0);
    step();
    Reset = 1'b1;
    Start = 1'b1; Mode = 2'b11;
    Shift_Cnt = 5'd3; Serial_In = 1'b1;
    step();
    Start = 1'b0;
    chk("rel_busy", 32'(Busy), 32'h1);
    wait_done(nb, got);
    chk("rel_done", 32'(got), 32'h1);
    chk("rel_nb", 32'(nb), 32'd3);
    chk("rel_A", 32'(A), 32'h00);
    chk("rel_B", 32'(B), 32'h07);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
